// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
package div_seq_pkg;

    localparam int DEF_BUS_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_seq_sub.sv
// Ripple subtractor a - b built from full_adder cells (a + ~b + 1).
// borrow is high when b > a; kept generic so SUB/CMP/dec paths can reuse it.
module div_seq_sub import div_seq_pkg::*; #(
    parameter int WIDTH = DEF_BUS_WIDTH + 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (~b[i]),
            .cin  (carry[i]),
            .s    (diff[i]),
            .cout (carry[i+1])
        );
    end

    assign borrow = ~carry[WIDTH];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of the ripple datapaths.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and carry of three input bits.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/div_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
//
//  state | meaning
//  IDLE  | waiting for start
//  RUN   | shift-and-subtract iterations, busy high
//  DONE  | one-cycle result strobe; start here chains the next division
module div_seq import div_seq_pkg::*; #(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BUS_WIDTH-1:0] dividend,
    input  logic [BUS_WIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [BUS_WIDTH-1:0] quotient,
    output logic [BUS_WIDTH-1:0] remainder,
    output logic                 div_by_zero
);

    localparam int CNT_W = $clog2(BUS_WIDTH);

    state_t               state;
    state_t               state_nx;
    logic [CNT_W-1:0]     cnt;
    logic [BUS_WIDTH-1:0] q_reg;
    logic [BUS_WIDTH-1:0] r_reg;
    logic [BUS_WIDTH-1:0] d_reg;

    logic [BUS_WIDTH:0]   sub_a;
    logic [BUS_WIDTH:0]   sub_b;
    logic [BUS_WIDTH:0]   sub_diff;
    logic                 sub_borrow;
    logic                 diff_top_unused;
    logic [BUS_WIDTH-1:0] q_nx;
    logic [BUS_WIDTH-1:0] r_nx;
    logic                 accept;

    // Trial subtract of the divisor from the shifted partial remainder.
    assign sub_a = {r_reg, q_reg[BUS_WIDTH-1]};
    assign sub_b = {1'b0, d_reg};

    div_seq_sub #(.WIDTH(BUS_WIDTH + 1)) u_sub (
        .a      (sub_a),
        .b      (sub_b),
        .diff   (sub_diff),
        .borrow (sub_borrow)
    );

    // R < D holds every step, so a non-borrowing result always fits in BUS_WIDTH bits.
    assign diff_top_unused = sub_diff[BUS_WIDTH];

    // Keep the difference or restore, and shift the new quotient bit into Q.
    always_comb begin
        r_nx = sub_borrow ? sub_a[BUS_WIDTH-1:0] : sub_diff[BUS_WIDTH-1:0];
        q_nx = {q_reg[BUS_WIDTH-2:0], ~sub_borrow};
    end

    assign accept = start && ((state == IDLE) || (state == DONE));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nx = (divisor == '0) ? DONE : RUN;
                else       state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            q_reg       <= dividend;
            d_reg       <= divisor;
            r_reg       <= '0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
                cnt         <= '0;
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                cnt <= CNT_W'(BUS_WIDTH - 1);
            end
        end else if (state == RUN) begin
            q_reg <= q_nx;
            r_reg <= r_nx;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == '0) begin
                quotient  <= q_nx;
                remainder <= r_nx;
            end
        end
    end

endmodule
